// File: rtl/l2_ram_multi_bank_pipe.sv
// ---------------------------------------------------------------------------
// l2_ram_multi_bank_pipe
//   NB_BANKS word-interleaved L2 SRAM banks behind TCDM-style slave ports.
//   Each port is hard-wired to one bank. Responses come back after a fixed
//   RD_LATENCY (1..4) cycles. An init sequencer zero-fills every bank after
//   reset (INIT_ON_RESET=1) or when init_start_i is pulsed.
//
//   Optional build macro: L2_ACCESS_CNT_EN
//     defined   : per-bank 32-bit saturating access counters on cnt_o,
//                 cleared by cnt_clr_i (the clear wins over an increment).
//     undefined : cnt_o is tied to zero and cnt_clr_i is ignored.
//
// Ports
//   clk_i, rst_i     clock, asynchronous active-high reset
//   init_start_i     one-cycle pulse that starts a zero-fill (READY only)
//   init_busy_o      high while the zero-fill runs
//   req_i/wen_i      per-bank request / write enable (active low)
//   add_i            per-bank byte address (BASE_ADDR relative)
//   wdata_i/be_i     per-bank write data / byte enables
//   gnt_o            per-bank grant (combinational, READY only)
//   r_valid_o        per-bank response valid
//   r_rdata_o        per-bank read data
//   r_opc_o          error flag, always 0
//   cnt_clr_i/cnt_o  access counter clear / per-bank access counters
// ---------------------------------------------------------------------------
module l2_ram_multi_bank_pipe #(
   parameter int unsigned NB_BANKS      = 4,
   parameter int unsigned BANK_WORDS    = 32768,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned RD_LATENCY    = 1,
   parameter logic [31:0] BASE_ADDR     = 32'h1C01_0000,
   parameter bit          INIT_ON_RESET = 1'b1
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             init_start_i,
   output logic                             init_busy_o,
   input  logic [NB_BANKS-1:0]              req_i,
   input  logic [NB_BANKS-1:0]              wen_i,
   input  logic [NB_BANKS*32-1:0]           add_i,
   input  logic [NB_BANKS*DATA_WIDTH-1:0]   wdata_i,
   input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
   output logic [NB_BANKS-1:0]              gnt_o,
   output logic [NB_BANKS-1:0]              r_valid_o,
   output logic [NB_BANKS*DATA_WIDTH-1:0]   r_rdata_o,
   output logic [NB_BANKS-1:0]              r_opc_o,
   input  logic                             cnt_clr_i,
   output logic [NB_BANKS*32-1:0]           cnt_o
);

   localparam int unsigned AW     = $clog2(BANK_WORDS);
   localparam int unsigned BSEL_W = $clog2(NB_BANKS);
   localparam int unsigned NBE    = DATA_WIDTH / 8;

   if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $fatal(1, "l2_ram_multi_bank_pipe: RD_LATENCY must be within 1..4");
   end

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   init_cnt_q, init_cnt_d;
   logic [NB_BANKS-1:0] acc;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= INIT_ON_RESET ? ST_INIT : ST_READY;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   // The word counter wraps naturally; leaving INIT on the wrap edge makes
   // the fill last exactly BANK_WORDS cycles.
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == AW'(BANK_WORDS - 1)) state_d = ST_READY;
         end
         default: begin
            init_cnt_d = '0;
            if (init_start_i) state_d = ST_INIT;
         end
      endcase
   end

   assign init_busy_o = (state_q == ST_INIT);
   assign gnt_o       = (state_q == ST_READY && !rst_i) ? req_i : '0;
   assign acc         = req_i & gnt_o;
   assign r_opc_o     = '0;

`ifdef L2_ACCESS_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr_i;
`endif

   for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
      logic [DATA_WIDTH-1:0] mem [BANK_WORDS];
      logic [31:0]           offset;
      logic [AW-1:0]         word;
      logic                  wr_en;
      logic [AW-1:0]         wr_addr;
      logic [DATA_WIDTH-1:0] wr_data;
      logic [NBE-1:0]        wr_be;
      logic [RD_LATENCY-1:0] vld_p;
      logic [DATA_WIDTH-1:0] rd_p [RD_LATENCY];

      // Bank-select and byte-offset bits are dropped; upper bits alias.
      assign offset = add_i[b*32 +: 32] - BASE_ADDR;
      assign word   = AW'(offset >> (2 + BSEL_W));

      always_comb begin
         wr_en   = 1'b0;
         wr_addr = word;
         wr_data = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
         wr_be   = be_i[b*NBE +: NBE];
         if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt_q;
            wr_data = '0;
            wr_be   = '1;
         end else if (acc[b] && !wen_i[b]) begin
            wr_en = 1'b1;
         end
      end

      always_ff @(posedge clk_i) begin
         if (wr_en) begin
            for (int k = 0; k < NBE; k++) begin
               if (wr_be[k]) mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
            end
         end
      end

      // Stage p0 captures the array on the grant edge; later stages only
      // delay the response so ordering with later writes is preserved.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_p <= '0;
            for (int s = 0; s < RD_LATENCY; s++) rd_p[s] <= '0;
         end else begin
            vld_p[0] <= acc[b];
            if (acc[b]) rd_p[0] <= mem[word];
            for (int s = 1; s < RD_LATENCY; s++) begin
               vld_p[s] <= vld_p[s-1];
               if (vld_p[s-1]) rd_p[s] <= rd_p[s-1];
            end
         end
      end

      assign r_valid_o[b]                           = vld_p[RD_LATENCY-1];
      assign r_rdata_o[b*DATA_WIDTH +: DATA_WIDTH]  = rd_p[RD_LATENCY-1];

`ifdef L2_ACCESS_CNT_EN
      logic [31:0] cnt_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i)          cnt_q <= '0;
         else if (cnt_clr_i) cnt_q <= '0;
         else if (acc[b])    cnt_q <= sat_inc(cnt_q);
      end
      assign cnt_o[b*32 +: 32] = cnt_q;
`else
      assign cnt_o[b*32 +: 32] = '0;
`endif
   end

endmodule

// File: tb/tb_l2_ram_multi_bank_pipe.sv
// ---------------------------------------------------------------------------
// tb_l2_ram_multi_bank_pipe
//   Scoreboard bench: every granted access pushes its expected response
//   (due cycle, read data from a word-array model) into a per-bank queue; a
//   negedge monitor pops and compares whenever r_valid_o is seen.
//   Configuration: NB_BANKS=4, BANK_WORDS=1024, RD_LATENCY=2, INIT_ON_RESET=1.
// ---------------------------------------------------------------------------
module tb_l2_ram_multi_bank_pipe;

   localparam int NB  = 4;
   localparam int BW  = 1024;
   localparam int DW  = 32;
   localparam int LAT = 2;
   localparam logic [31:0] BASE = 32'h1C01_0000;
`ifdef L2_ACCESS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            init_start_i = 1'b0;
   logic            init_busy_o;
   logic [NB-1:0]   req_i = '0;
   logic [NB-1:0]   wen_i = '1;
   logic [NB*32-1:0] add_i = '0;
   logic [NB*DW-1:0] wdata_i = '0;
   logic [NB*DW/8-1:0] be_i = '0;
   logic [NB-1:0]   gnt_o;
   logic [NB-1:0]   r_valid_o;
   logic [NB*DW-1:0] r_rdata_o;
   logic [NB-1:0]   r_opc_o;
   logic            cnt_clr_i = 1'b0;
   logic [NB*32-1:0] cnt_o;

   l2_ram_multi_bank_pipe #(
      .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(DW), .RD_LATENCY(LAT),
      .BASE_ADDR(BASE), .INIT_ON_RESET(1'b1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .init_start_i(init_start_i),
      .init_busy_o(init_busy_o), .req_i(req_i), .wen_i(wen_i), .add_i(add_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
      .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .cnt_clr_i(cnt_clr_i),
      .cnt_o(cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      int          due;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sbq [NB][$];
   logic [31:0] mdl [NB][BW];
   logic [31:0] cnt_exp [NB];
   int          init_left = 0;

   logic [NB-1:0] s_req;
   logic [NB-1:0] s_wen;
   logic [31:0]   s_add [NB];
   logic [31:0]   s_wd  [NB];
   logic [3:0]    s_be  [NB];
   logic          s_init;
   logic          s_clr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mdl_reset();
      for (int b = 0; b < NB; b++) begin
         for (int w = 0; w < BW; w++) mdl[b][w] = '0;
      end
   endtask

   task automatic clr_stim();
      s_req = '0; s_wen = '1; s_init = 1'b0; s_clr = 1'b0;
      for (int b = 0; b < NB; b++) begin
         s_add[b] = BASE; s_wd[b] = '0; s_be[b] = '0;
      end
   endtask

   task automatic lane(input int b, input bit wr, input int word,
                       input logic [31:0] d, input logic [3:0] be);
      s_req[b] = 1'b1;
      s_wen[b] = ~wr;
      s_add[b] = BASE + 32'((word * NB + b) * 4);
      s_wd[b]  = d;
      s_be[b]  = be;
   endtask

   // One clock cycle: drive, check outputs at negedge, update the model.
   task automatic step();
      bit          busy;
      logic [31:0] w;
      exp_t        e;
      req_i = s_req; wen_i = s_wen; init_start_i = s_init; cnt_clr_i = s_clr;
      for (int b = 0; b < NB; b++) begin
         add_i[b*32 +: 32]  = s_add[b];
         wdata_i[b*DW +: DW] = s_wd[b];
         be_i[b*4 +: 4]     = s_be[b];
      end
      @(negedge clk_i);
      busy = (init_left > 0);
      chk("init_busy", 32'(init_busy_o), 32'(busy));
      chk("gnt", 32'(gnt_o), busy ? 32'd0 : 32'(s_req));
      chk("opc", 32'(r_opc_o), 32'd0);
      for (int b = 0; b < NB; b++) chk("cnt", cnt_o[b*32 +: 32], cnt_exp[b]);
      if (!busy) begin
         for (int b = 0; b < NB; b++) begin
            if (s_req[b]) begin
               w = ((s_add[b] - BASE) >> 4) % 32'(BW);
               if (!s_wen[b]) begin
                  for (int k = 0; k < 4; k++)
                     if (s_be[b][k]) mdl[b][w][k*8 +: 8] = s_wd[b][k*8 +: 8];
               end
               e.due  = cyc + LAT;
               e.rd   = s_wen[b];
               e.data = mdl[b][w];
               sbq[b].push_back(e);
               if (CNT_EN && cnt_exp[b] != 32'hFFFF_FFFF) cnt_exp[b] = cnt_exp[b] + 1;
            end
         end
      end
      if (s_clr) begin
         for (int b = 0; b < NB; b++) cnt_exp[b] = '0;
      end
      if (init_left > 0) init_left--;
      else if (s_init) begin
         init_left = BW;
         mdl_reset();
      end
      @(posedge clk_i);
      #1;
      clr_stim();
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic run_init_random();
      while (init_left > 0) begin
         s_req = 4'($urandom());
         s_wen = 4'($urandom());
         for (int b = 0; b < NB; b++) begin
            s_add[b] = BASE + 32'($urandom_range(0, 4095)) * 4;
            s_wd[b]  = $urandom();
            s_be[b]  = 4'hF;
         end
         step();
      end
   endtask

   task automatic release_reset();
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      init_left = BW;
      mdl_reset();
      for (int b = 0; b < NB; b++) cnt_exp[b] = '0;
   endtask

   // Response monitor
   always @(negedge clk_i) begin
      exp_t e;
      if (!rst_i) begin
         for (int b = 0; b < NB; b++) begin
            if (r_valid_o[b]) begin
               if (sbq[b].size() == 0) begin
                  total++; bad++;
                  $display("FAIL stray_rvalid bank%0d: got r_valid=1 expected 0 (cycle %0d)", b, cyc);
               end else begin
                  e = sbq[b].pop_front();
                  chk("rvalid_cycle", 32'(cyc), 32'(e.due));
                  if (e.rd) chk("rdata", r_rdata_o[b*DW +: DW], e.data);
               end
            end else if (sbq[b].size() > 0 && sbq[b][0].due <= cyc) begin
               e = sbq[b].pop_front();
               total++; bad++;
               $display("FAIL missing_rvalid bank%0d: got r_valid=0 expected 1 (cycle %0d)", b, cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish by time 500000");
      $fatal(1, "timeout");
   end

   initial begin
      clr_stim();
      for (int b = 0; b < NB; b++) cnt_exp[b] = '0;
      repeat (2) @(negedge clk_i);
      chk("rst_gnt", 32'(gnt_o), 32'd0);
      chk("rst_rvalid", 32'(r_valid_o), 32'd0);
      chk("rst_opc", 32'(r_opc_o), 32'd0);
      chk("rst_busy", 32'(init_busy_o), 32'd1);
      for (int b = 0; b < NB; b++) begin
         chk("rst_rdata", r_rdata_o[b*DW +: DW], 32'd0);
         chk("rst_cnt", cnt_o[b*32 +: 32], 32'd0);
      end
      release_reset();

      // Zero-fill after reset, with requests that must be ignored.
      run_init_random();
      lane(2, 1'b0, 5, '0, '0); step();
      idle(3);

      // Write then read-after-write on the next cycle.
      lane(0, 1'b1, 5, 32'hDEAD_BEEF, 4'hF); step();
      lane(0, 1'b0, 5, '0, '0); step();
      idle(3);

      // Partial byte-enable write.
      lane(1, 1'b1, 9, 32'h1111_1111, 4'hF); step();
      lane(1, 1'b1, 9, 32'h0000_AB00, 4'b0010); step();
      lane(1, 1'b0, 9, '0, '0); step();
      idle(3);

      // All banks busy for 8 consecutive cycles.
      for (int i = 0; i < 8; i++) begin
         for (int b = 0; b < NB; b++)
            lane(b, 1'($urandom()), $urandom_range(0, 15), $urandom(), 4'($urandom()));
         step();
      end
      idle(3);

      // Zero-fill requested while a read is in flight.
      lane(3, 1'b1, 7, 32'hCAFE_F00D, 4'hF); step();
      lane(3, 1'b0, 7, '0, '0); step();
      s_init = 1'b1; step();
      run_init_random();
      lane(3, 1'b0, 7, '0, '0);
      lane(0, 1'b0, 5, '0, '0);
      lane(1, 1'b0, 9, '0, '0);
      step();
      idle(3);

      // Access counters.
      s_clr = 1'b1; step();
      for (int i = 0; i < 10; i++) begin
         lane(3, 1'($urandom()), i, $urandom(), 4'hF); step();
      end
      idle(1);
      lane(3, 1'b0, 0, '0, '0); s_clr = 1'b1; step();
      idle(2);

      // Randomized traffic with aliased upper address bits.
      for (int i = 0; i < 300; i++) begin
         for (int b = 0; b < NB; b++) begin
            if ($urandom_range(0, 3) != 0) begin
               lane(b, 1'($urandom()), $urandom_range(0, 15), $urandom(), 4'($urandom()));
               s_add[b] = s_add[b] + 32'($urandom_range(0, 3)) * 32'h4000
                          + 32'($urandom_range(0, 3) * 16 + $urandom_range(0, 3));
            end
         end
         s_clr = ($urandom_range(0, 19) == 0);
         step();
      end
      idle(3);

      // Reset in the middle of an access flushes the response.
      lane(2, 1'b0, 3, '0, '0);
      req_i = s_req; wen_i = s_wen;
      add_i[2*32 +: 32] = s_add[2];
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      clr_stim();
      req_i = '0;
      for (int b = 0; b < NB; b++) sbq[b].delete();
      repeat (3) begin
         @(negedge clk_i);
         chk("rst_mid_rvalid", 32'(r_valid_o), 32'd0);
         chk("rst_mid_busy", 32'(init_busy_o), 32'd1);
      end
      release_reset();
      run_init_random();
      lane(2, 1'b0, 3, '0, '0);
      lane(0, 1'b0, 5, '0, '0);
      step();
      idle(4);

      for (int b = 0; b < NB; b++) chk("drain", 32'(sbq[b].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l2_ram_multi_bank_pipe.md
Name: l2_ram_multi_bank_pipe

Overview:
Parametrised successor of the interleaved L2 bank array. It provides NB_BANKS word-interleaved SRAM banks behind TCDM-style slave ports. Read/write latency is configurable from 1 to 4 cycles, and a hardware init sequencer zero-fills all banks after reset or on request. It sits between the SoC L2 crossbar and the L2 SRAM macros or behavioural arrays, and replaces the fixed 1-cycle interleaved region.

Parameters:
- NB_BANKS, 4: number of interleaved banks; power of two, ≥1.
- BANK_WORDS, 32768: words per bank; power of two.
- DATA_WIDTH, 32: word width in bits; multiple of 8.
- RD_LATENCY, 1: cycles from grant to r_valid; legal range 1..4; elaboration $fatal outside this range.
- BASE_ADDR, 32'h1C01_0000: byte base address subtracted from add_i.
- INIT_ON_RESET, 1: 1 = start zero-fill automatically on reset release.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- init_start_i  in  1  single-cycle pulse; requests a zero-fill.
- init_busy_o  out  1  high while the zero-fill runs.
- req_i  in  NB_BANKS  per-bank request.
- wen_i  in  NB_BANKS  per-bank write enable, active low (0 = write).
- add_i  in  NB_BANKS*32  per-bank byte address.
- wdata_i  in  NB_BANKS*DATA_WIDTH  write data.
- be_i  in  NB_BANKS*DATA_WIDTH/8  byte enables.
- gnt_o  out  NB_BANKS  grant.
- r_valid_o  out  NB_BANKS  response valid.
- r_rdata_o  out  NB_BANKS*DATA_WIDTH  read data.
- r_opc_o  out  NB_BANKS  error flag; constant 0.
- cnt_clr_i  in  1  clears access counters.
- cnt_o  out  NB_BANKS*32  per-bank access counters.

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: gnt_o=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, cnt_o=0.
- Reset value of init_busy_o: 1 if INIT_ON_RESET=1, else 0.
- Word index = (add_i − BASE_ADDR)[log2(BANK_WORDS)+2+log2(NB_BANKS)−1 : 2+log2(NB_BANKS)].
- Upper address bits are ignored, so out-of-range addresses alias. No error is raised.
- FSM states: INIT, READY.
  - Reset enters INIT when INIT_ON_RESET=1, else READY.
  - INIT: a word counter runs 0..BANK_WORDS−1. Each cycle it writes all-zero data with all byte enables set to that index in every bank simultaneously. gnt_o=0 and requests are ignored.
  - The counter wraps at BANK_WORDS−1 and the FSM goes to READY on the next edge. INIT therefore lasts exactly BANK_WORDS cycles.
  - READY: gnt_o[i]=req_i[i], combinationally. Zero wait states.
  - init_start_i=1 in READY enters INIT next cycle with the counter at 0.
  - init_start_i is ignored while in INIT.
  - init_busy_o = (state==INIT), registered.
- Accesses:
  - A granted access (req&gnt) in cycle t raises r_valid_o[i] in cycle t+RD_LATENCY. It is high for exactly one cycle per granted access.
  - The response pipeline is a RD_LATENCY-deep shift of valid, with data registered in the last stage.
  - Back-to-back requests are accepted every cycle. No backpressure on responses.
  - Writes also produce r_valid_o. r_rdata_o for a write is don't-care; the bench must not check it.
  - Only lanes with be set are written.
  - A read following a write to the same address in the next cycle returns the new data.
- Responses already in the pipeline when INIT is entered still complete on schedule.
- Reset mid-init or mid-access: the pipeline is flushed (no r_valid) and the FSM returns to its reset state.
- Banks are independent. Simultaneous requests to all banks are all granted.

Optional Feature:
Macro: L2_ACCESS_CNT_EN
- Defined:
  - cnt_o[i] is a 32-bit saturating counter (stops at 32'hFFFF_FFFF).
  - It increments by 1 on each granted access to bank i, read or write.
  - Init-sequencer writes are not counted.
  - cnt_clr_i=1 zeroes all counters next cycle. A clear takes priority over an increment in the same cycle.
- Undefined: counters are not built, cnt_o is tied to 0, and cnt_clr_i is ignored.

Test Plan (NB_BANKS=4, BANK_WORDS=1024, RD_LATENCY=2, INIT_ON_RESET=1):
1. Release reset → init_busy_o=1 for 1024 cycles, gnt_o=0 throughout. Then read bank 2, word 5 → r_rdata=0 at t+2.
2. Write 32'hDEAD_BEEF, be=4'b1111, to BASE_ADDR+0x50 (bank 0, word 5) at t, then read the same address at t+1 → r_valid at t+2 (write ack) and t+3. Read data = 32'hDEADBEEF.
3. Write be=4'b0010, data 32'h0000_AB00 over 32'h1111_1111 → read returns 32'h1111_AB11.
4. Requests on all 4 banks for 8 consecutive cycles → gnt_o=4'hF each cycle. r_valid_o=4'hF for 8 cycles starting 2 cycles later.
5. Pulse init_start_i while a read is in flight → that read's r_valid still arrives. gnt_o=0 for 1024 cycles. Previously written words then read 0.
6. With L2_ACCESS_CNT_EN defined: 10 accesses to bank 3 → cnt_o[3]=10, others 0. Assert cnt_clr_i together with an access → counter=0.
